// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the MIPS multicycle controller: opcodes, funct codes,
// state encodings, ALUOp and ALUControl codes, and datapath mux selects.
package mips_ctrl_pkg;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (Instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Controller states, 4-bit encoding visible on the State debug port
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Coarse ALU operation requested by the FSM
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // ALUControl codes
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PCSrc selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath signal bundle. The master side is the controller
// (consumes IR/ALU status, drives selects and enables); the slave side is
// the datapath.
interface multicycle_ctrl_fsm_if #(
    parameter int OP_W     = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUCTL_W = 3
);
    logic [OP_W-1:0]     Op;
    logic [FUNCT_W-1:0]  Funct;
    logic                Zero;
    logic                MemReady;
    logic                IorD;
    logic                MemWrite;
    logic                IRWrite;
    logic                RegDst;
    logic                MemtoReg;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [ALUCTL_W-1:0] ALUControl;
    logic [1:0]          PCSrc;
    logic                PCEn;
    logic                InstrDone;
    logic                IllegalOp;
    logic [3:0]          State;

    modport master (
        input  Op, Funct, Zero, MemReady,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUControl, PCSrc, PCEn, InstrDone, IllegalOp, State
    );

    modport slave (
        output Op, Funct, Zero, MemReady,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUControl, PCSrc, PCEn, InstrDone, IllegalOp, State
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// ALU decoder: maps the FSM's coarse ALUOp plus the R-type funct field onto
// the ALUControl code. Unknown funct values fall back to add.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int FUNCT_W  = 6,
    parameter int ALUCTL_W = 3
) (
    input  aluop_t              i_alu_op,
    input  logic [FUNCT_W-1:0]  i_funct,
    output logic [ALUCTL_W-1:0] o_alu_control
);

    // Select ALU operation from ALUOp, consulting Funct only for R-type execute
    always_comb begin
        o_alu_control = ALUCTL_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALUCTL_ADD;
            ALUOP_SUB: o_alu_control = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALUCTL_ADD;
                    FN_SUB:  o_alu_control = ALUCTL_SUB;
                    FN_AND:  o_alu_control = ALUCTL_AND;
                    FN_OR:   o_alu_control = ALUCTL_OR;
                    FN_SLT:  o_alu_control = ALUCTL_SLT;
                    default: o_alu_control = ALUCTL_ADD;
                endcase
            end
            default: o_alu_control = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller for the MIPS multicycle datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, stalling on the
// shared memory's ready handshake, and decodes all datapath selects and
// enables from the current state (Moore), except PCEn and the MemReady-gated
// fetch/store enables.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUCTL_W = 3
) (
    input logic                  CLK,
    input logic                  RST,
    multicycle_ctrl_fsm_if.master bus
);

    state_t              r_state;
    state_t              w_next_state;
    logic [OP_W-1:0]     w_op;
    logic [FUNCT_W-1:0]  w_funct;
    logic [ALUCTL_W-1:0] w_alu_control;
    aluop_t              w_alu_op;
    logic                w_mem_ready;
    logic                w_pc_write;
    logic                w_branch;
    logic                w_mem_write;
    logic                w_ir_write;
    logic                w_reg_write;
    logic                w_instr_done;
    logic                w_illegal_op;
    logic                w_iord;
    logic                w_reg_dst;
    logic                w_mem_to_reg;
    logic                w_alu_src_a;
    logic [1:0]          w_alu_src_b;
    logic [1:0]          w_pc_src;

    assign w_op        = bus.Op;
    assign w_funct     = bus.Funct;
    assign w_mem_ready = bus.MemReady;

    alu_decoder #(
        .FUNCT_W  (FUNCT_W),
        .ALUCTL_W (ALUCTL_W)
    ) u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct       (w_funct),
        .o_alu_control (w_alu_control)
    );

    // State register; reset abandons any instruction in flight and restarts at fetch
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    // Next-state selection and per-state datapath control decode
    always_comb begin
        w_next_state = r_state;
        w_alu_op     = ALUOP_ADD;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_illegal_op = 1'b0;
        w_iord       = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_B;
        w_pc_src     = PCSRC_ALU;
        case (r_state)
            S_FETCH: begin
                // PC+4 computed every cycle; IR and PC only commit on the ready cycle
                w_alu_src_b = SRCB_FOUR;
                w_ir_write  = w_mem_ready;
                w_pc_write  = w_mem_ready;
                if (w_mem_ready) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute branch target into ALUOut
                w_alu_src_b = SRCB_IMMSH;
                case (w_op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                if (w_op == OP_SW) w_next_state = S_MEMWR;
                else               w_next_state = S_MEMRD;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                if (w_mem_ready) w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe held until the memory accepts; it samples on the ready cycle
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (w_mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_B;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_B;
                w_alu_op     = ALUOP_SUB;
                w_pc_src     = PCSRC_ALUOUT;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_ADDIEX: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src     = PCSRC_JUMP;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Architectural side effects and pulses are suppressed in any reset cycle
    assign bus.MemWrite   = w_mem_write  & ~RST;
    assign bus.IRWrite    = w_ir_write   & ~RST;
    assign bus.RegWrite   = w_reg_write  & ~RST;
    assign bus.PCEn       = (w_pc_write | (w_branch & bus.Zero)) & ~RST;
    assign bus.InstrDone  = w_instr_done & ~RST;
    assign bus.IllegalOp  = w_illegal_op & ~RST;

    assign bus.IorD       = w_iord;
    assign bus.RegDst     = w_reg_dst;
    assign bus.MemtoReg   = w_mem_to_reg;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ALUControl = w_alu_control;
    assign bus.PCSrc      = w_pc_src;
    assign bus.State      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for the multicycle MIPS controller.
module tb_multicycle_ctrl_fsm;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Two reset cycles: State goes to FETCH, no enables or pulses escape
    task automatic test_reset();
        rst = 1'b1;
        bus.MemReady = 1'b1;
        bus.Op = 6'b000000;
        bus.Funct = 6'b100000;
        bus.Zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            n_checks++;
            if (bus.State !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %0d expected 0", i, bus.State);
            end
            n_checks++;
            if ({bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCEn, bus.InstrDone, bus.IllegalOp} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_enables[%0d]: got %b expected 000000", i,
                         {bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCEn, bus.InstrDone, bus.IllegalOp});
            end
        end
        rst = 1'b0;
    endtask

    // R-type sub: FETCH, DECODE, EXEC (sub), ALUWB
    task automatic test_rtype();
        int exp_st [4] = '{0, 1, 6, 7};
        bus.Op = 6'b000000; bus.Funct = 6'b100010; bus.MemReady = 1'b1; bus.Zero = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(posedge clk);
            #2;
            n_checks++;
            if (bus.State !== 4'(exp_st[c])) begin
                n_fail++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", c, bus.State, exp_st[c]);
            end
            n_checks++;
            if (bus.InstrDone !== (c == 3)) begin
                n_fail++; $display("FAIL rtype_done[%0d]: got %b expected %b", c, bus.InstrDone, (c == 3));
            end
            if (c == 0) begin
                n_checks++;
                if ({bus.IRWrite, bus.PCEn, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc} !== 8'b11_0_0_01_00) begin
                    n_fail++; $display("FAIL rtype_fetch_ctl: got %b expected 11000100",
                                       {bus.IRWrite, bus.PCEn, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc});
                end
            end
            if (c == 1) begin
                n_checks++;
                if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl} !== 6'b0_11_010) begin
                    n_fail++; $display("FAIL rtype_decode_ctl: got %b expected 011010",
                                       {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl});
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite} !== 7'b1_00_110_0) begin
                    n_fail++; $display("FAIL rtype_exec_ctl: got %b expected 1001100",
                                       {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite});
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 3'b110) begin
                    n_fail++; $display("FAIL rtype_wb_ctl: got %b expected 110",
                                       {bus.RegWrite, bus.RegDst, bus.MemtoReg});
                end
            end
        end
        @(posedge clk); #2;
        n_checks++;
        if (bus.State !== 4'd0) begin
            n_fail++; $display("FAIL rtype_return: got %0d expected 0", bus.State);
        end
    endtask

    // Funct table: EXEC ALUControl for each funct, unknown funct -> add
    task automatic test_funct();
        logic [5:0] fn  [5] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        logic [2:0] ctl [5] = '{3'b010,    3'b000,    3'b001,    3'b111,    3'b010};
        bus.Op = 6'b000000; bus.MemReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.Funct = fn[k];
            @(posedge clk); @(posedge clk); #2;
            n_checks++;
            if (bus.State !== 4'd6 || bus.ALUControl !== ctl[k]) begin
                n_fail++; $display("FAIL funct_%b: got state %0d ctl %b expected state 6 ctl %b",
                                   fn[k], bus.State, bus.ALUControl, ctl[k]);
            end
            @(posedge clk); @(posedge clk); #2;
        end
    endtask

    // lw with MemReady low for 2 cycles in MEMRD: 7 cycles total
    task automatic test_lw_wait();
        int   exp_st [7] = '{0, 1, 2, 3, 3, 3, 4};
        logic mr     [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.Op = 6'b100011; bus.Funct = 6'b000000;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(posedge clk);
            #1; bus.MemReady = mr[c]; #1;
            n_checks++;
            if (bus.State !== 4'(exp_st[c])) begin
                n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", c, bus.State, exp_st[c]);
            end
            n_checks++;
            if (bus.InstrDone !== (c == 6)) begin
                n_fail++; $display("FAIL lw_done[%0d]: got %b expected %b", c, bus.InstrDone, (c == 6));
            end
            if (c == 2) begin
                n_checks++;
                if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl} !== 6'b1_10_010) begin
                    n_fail++; $display("FAIL lw_memadr_ctl: got %b expected 110010",
                                       {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl});
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({bus.IorD, bus.RegWrite, bus.MemWrite, bus.IRWrite} !== 4'b1000) begin
                    n_fail++; $display("FAIL lw_memrd_ctl: got %b expected 1000",
                                       {bus.IorD, bus.RegWrite, bus.MemWrite, bus.IRWrite});
                end
            end
            if (c == 6) begin
                n_checks++;
                if ({bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 3'b101) begin
                    n_fail++; $display("FAIL lw_memwb_ctl: got %b expected 101",
                                       {bus.RegWrite, bus.RegDst, bus.MemtoReg});
                end
            end
        end
        @(posedge clk); #2;
        n_checks++;
        if (bus.State !== 4'd0) begin
            n_fail++; $display("FAIL lw_return: got %0d expected 0", bus.State);
        end
    endtask

    // beq taken (Zero=1) and not taken (Zero=0), 3 cycles each
    task automatic test_beq();
        logic z [2] = '{1'b1, 1'b0};
        bus.Op = 6'b000100; bus.MemReady = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.Zero = z[k];
            @(posedge clk); #2;
            n_checks++;
            if (bus.State !== 4'd1) begin
                n_fail++; $display("FAIL beq%0d_decode_state: got %0d expected 1", k, bus.State);
            end
            @(posedge clk); #2;
            n_checks++;
            if (bus.State !== 4'd8 || bus.InstrDone !== 1'b1) begin
                n_fail++; $display("FAIL beq%0d_branch: got state %0d done %b expected state 8 done 1",
                                   k, bus.State, bus.InstrDone);
            end
            n_checks++;
            if ({bus.PCEn, bus.PCSrc, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB} !== {z[k], 2'b01, 3'b110, 1'b1, 2'b00}) begin
                n_fail++; $display("FAIL beq%0d_ctl: got %b expected %b", k,
                                   {bus.PCEn, bus.PCSrc, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB},
                                   {z[k], 2'b01, 3'b110, 1'b1, 2'b00});
            end
            @(posedge clk); #2;
            n_checks++;
            if (bus.State !== 4'd0) begin
                n_fail++; $display("FAIL beq%0d_return: got %0d expected 0", k, bus.State);
            end
        end
        bus.Zero = 1'b0;
    endtask

    // Unsupported opcode: IllegalOp pulse in DECODE, back to FETCH, no writes
    task automatic test_illegal();
        bus.Op = 6'b111111; bus.MemReady = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if ({bus.State, bus.IllegalOp, bus.RegWrite, bus.MemWrite, bus.InstrDone} !== {4'd1, 4'b1000}) begin
            n_fail++; $display("FAIL illegal_decode: got %b expected 00011000",
                               {bus.State, bus.IllegalOp, bus.RegWrite, bus.MemWrite, bus.InstrDone});
        end
        @(posedge clk); #2;
        n_checks++;
        if (bus.State !== 4'd0 || bus.IllegalOp !== 1'b0) begin
            n_fail++; $display("FAIL illegal_return: got state %0d illegal %b expected state 0 illegal 0",
                               bus.State, bus.IllegalOp);
        end
    endtask

    // addi: FETCH, DECODE, ADDIEX, ADDIWB
    task automatic test_addi();
        bus.Op = 6'b001000; bus.MemReady = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        n_checks++;
        if ({bus.State, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl} !== {4'd9, 1'b1, 2'b10, 3'b010}) begin
            n_fail++; $display("FAIL addi_ex: got %b expected %b",
                               {bus.State, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl}, {4'd9, 1'b1, 2'b10, 3'b010});
        end
        @(posedge clk); #2;
        n_checks++;
        if ({bus.State, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.InstrDone} !== {4'd10, 4'b1001}) begin
            n_fail++; $display("FAIL addi_wb: got %b expected %b",
                               {bus.State, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.InstrDone}, {4'd10, 4'b1001});
        end
        @(posedge clk); #2;
    endtask

    // sw preceded by a stalled fetch; store completes on first ready MEMWR cycle
    task automatic test_fetch_stall_sw();
        int   exp_st [5] = '{0, 0, 1, 2, 5};
        logic mr     [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bus.Op = 6'b101011;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(posedge clk);
            #1; bus.MemReady = mr[c]; #1;
            n_checks++;
            if (bus.State !== 4'(exp_st[c])) begin
                n_fail++; $display("FAIL sw_state[%0d]: got %0d expected %0d", c, bus.State, exp_st[c]);
            end
            if (c < 2) begin
                n_checks++;
                if ({bus.IRWrite, bus.PCEn} !== {mr[c], mr[c]}) begin
                    n_fail++; $display("FAIL sw_fetch_en[%0d]: got %b expected %b", c,
                                       {bus.IRWrite, bus.PCEn}, {mr[c], mr[c]});
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({bus.MemWrite, bus.IorD, bus.InstrDone, bus.RegWrite} !== 4'b1110) begin
                    n_fail++; $display("FAIL sw_memwr: got %b expected 1110",
                                       {bus.MemWrite, bus.IorD, bus.InstrDone, bus.RegWrite});
                end
            end
        end
        @(posedge clk); #2;
        n_checks++;
        if (bus.State !== 4'd0) begin
            n_fail++; $display("FAIL sw_return: got %0d expected 0", bus.State);
        end
    endtask

    // sw stalled in MEMWR, then reset asserted: strobe killed, back to FETCH
    task automatic test_sw_reset();
        int   exp_st [5] = '{0, 1, 2, 5, 5};
        logic mr     [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus.Op = 6'b101011;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(posedge clk);
            #1; bus.MemReady = mr[c]; rst = (c == 4); #1;
            n_checks++;
            if (bus.State !== 4'(exp_st[c])) begin
                n_fail++; $display("FAIL swrst_state[%0d]: got %0d expected %0d", c, bus.State, exp_st[c]);
            end
            if (c >= 3) begin
                n_checks++;
                if ({bus.MemWrite, bus.InstrDone} !== {(c == 3), 1'b0}) begin
                    n_fail++; $display("FAIL swrst_memwr[%0d]: got %b expected %b", c,
                                       {bus.MemWrite, bus.InstrDone}, {(c == 3), 1'b0});
                end
            end
        end
        @(posedge clk); #1; rst = 1'b0; bus.MemReady = 1'b1; #1;
        n_checks++;
        if (bus.State !== 4'd0) begin
            n_fail++; $display("FAIL swrst_return: got %0d expected 0", bus.State);
        end
    endtask

    // j: FETCH, DECODE, JUMP with PCSrc=10 and PCEn=1
    task automatic test_jump();
        bus.Op = 6'b000010; bus.MemReady = 1'b1; bus.Zero = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        n_checks++;
        if ({bus.State, bus.PCSrc, bus.PCEn, bus.InstrDone} !== {4'd11, 2'b10, 2'b11}) begin
            n_fail++; $display("FAIL jump_ctl: got %b expected %b",
                               {bus.State, bus.PCSrc, bus.PCEn, bus.InstrDone}, {4'd11, 2'b10, 2'b11});
        end
        @(posedge clk); #2;
        n_checks++;
        if (bus.State !== 4'd0) begin
            n_fail++; $display("FAIL jump_return: got %0d expected 0", bus.State);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        test_reset();
        test_rtype();
        test_funct();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_addi();
        test_fetch_stall_sw();
        test_sw_reset();
        test_jump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
